yuv_to_rgb_pipe: RTL and testbench

YUV_TO_RGB_PIPE -- requirements
Module: yuv_to_rgb_pipe

---
 rtl/yuv_to_rgb_pipe.sv | 216 +++++++++++++++++++++
 tb/tb_yuv_to_rgb_pipe.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/yuv_to_rgb_pipe.sv
// Three-stage YUV to RGB colour-space converter with frame sequencing (BT.601 / BT.709).
// Define YUV2RGB_CLIP_CNT_EN to add the clip_cnt output counting clipped pixels.
module yuv_to_rgb_pipe #(
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned FRAC_W = 16,
  parameter int unsigned CNT_W  = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] frame_pixels,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] y_in,
  input  logic [PIX_W-1:0] u_in,
  input  logic [PIX_W-1:0] v_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] r_out,
  output logic [PIX_W-1:0] g_out,
  output logic [PIX_W-1:0] b_out,
  output logic             out_last,
  output logic             busy,
  output logic             frame_done
`ifdef YUV2RGB_CLIP_CNT_EN
  ,
  output logic [CNT_W-1:0] clip_cnt
`endif
);

  localparam int unsigned DW = PIX_W + 2;   // offset-removed component
  localparam int unsigned CW = FRAC_W + 3;  // signed coefficient
  localparam int unsigned PW = DW + CW;     // product
  localparam int unsigned SW = PW + 2;      // three-term sum plus rounding

  function automatic logic signed [CW-1:0] scale(input longint c);
    longint s;
    if (FRAC_W >= 16) s = c <<< (FRAC_W - 16);
    else              s = c >>> (16 - FRAC_W);
    return CW'(s);
  endfunction

  localparam logic signed [CW-1:0] C_Y      = scale(76284);
  localparam logic signed [CW-1:0] C601_RV  = scale(104595);
  localparam logic signed [CW-1:0] C601_GU  = scale(-25624);
  localparam logic signed [CW-1:0] C601_GV  = scale(-53281);
  localparam logic signed [CW-1:0] C601_BU  = scale(132251);
  localparam logic signed [CW-1:0] C709_RV  = scale(117506);
  localparam logic signed [CW-1:0] C709_GU  = scale(-13959);
  localparam logic signed [CW-1:0] C709_GV  = scale(-34931);
  localparam logic signed [CW-1:0] C709_BU  = scale(138412);

  localparam logic signed [DW-1:0] Y_OFF = DW'(16 << (PIX_W - 8));
  localparam logic signed [DW-1:0] C_OFF = DW'(128 << (PIX_W - 8));
  localparam logic signed [SW-1:0] RND   = SW'(longint'(1) << (FRAC_W - 1));
  localparam logic signed [SW-1:0] MAXV  = SW'((longint'(1) << PIX_W) - 1);

  function automatic logic [PIX_W-1:0] clip(input logic signed [SW-1:0] x);
    if (x < 0)    return '0;
    if (x > MAXV) return '1;
    return x[PIX_W-1:0];
  endfunction

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;

  logic adv, accept, last_in;

  logic                 s1_valid_q, s1_last_q;
  logic signed [DW-1:0] s1_y_q, s1_u_q, s1_v_q;
  logic                 s2_valid_q, s2_last_q;
  logic signed [PW-1:0] p_y_q, p_rv_q, p_gu_q, p_gv_q, p_bu_q;
  logic                 out_valid_q, out_last_q;
  logic [PIX_W-1:0]     r_q, g_q, b_q;

  logic signed [CW-1:0] c_rv, c_gu, c_gv, c_bu;
  logic signed [SW-1:0] sh_r, sh_g, sh_b;

  assign adv      = ~out_valid_q | out_ready;
  assign in_ready = adv & (state_q == StRun) & (cnt_q != '0);
  assign accept   = in_valid & in_ready;
  assign last_in  = (cnt_q == CNT_W'(1));

  // Frame sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d  = frame_pixels;
          mode_d = mode;
          if (frame_pixels == '0) done_d  = 1'b1;
          else                    state_d = StRun;
        end
      end
      StRun: begin
        if (accept) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (last_in) state_d = StDrain;
        end
      end
      StDrain: begin
        if (out_valid_q & out_ready & out_last_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  // Mode is only reloaded in idle, when the pipeline is empty
  assign c_rv = mode_q ? C709_RV : C601_RV;
  assign c_gu = mode_q ? C709_GU : C601_GU;
  assign c_gv = mode_q ? C709_GV : C601_GV;
  assign c_bu = mode_q ? C709_BU : C601_BU;

  always_comb begin
    sh_r = (SW'(p_y_q) + SW'(p_rv_q) + RND) >>> FRAC_W;
    sh_g = (SW'(p_y_q) + SW'(p_gu_q) + SW'(p_gv_q) + RND) >>> FRAC_W;
    sh_b = (SW'(p_y_q) + SW'(p_bu_q) + RND) >>> FRAC_W;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_y_q      <= '0;
      s1_u_q      <= '0;
      s1_v_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      p_y_q       <= '0;
      p_rv_q      <= '0;
      p_gu_q      <= '0;
      p_gv_q      <= '0;
      p_bu_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
    end else if (adv) begin
      s1_valid_q  <= accept;
      s1_last_q   <= accept & last_in;
      s1_y_q      <= $signed({2'b00, y_in}) - Y_OFF;
      s1_u_q      <= $signed({2'b00, u_in}) - C_OFF;
      s1_v_q      <= $signed({2'b00, v_in}) - C_OFF;
      s2_valid_q  <= s1_valid_q;
      s2_last_q   <= s1_last_q;
      p_y_q       <= PW'(s1_y_q) * PW'(C_Y);
      p_rv_q      <= PW'(s1_v_q) * PW'(c_rv);
      p_gu_q      <= PW'(s1_u_q) * PW'(c_gu);
      p_gv_q      <= PW'(s1_v_q) * PW'(c_gv);
      p_bu_q      <= PW'(s1_u_q) * PW'(c_bu);
      out_valid_q <= s2_valid_q;
      out_last_q  <= s2_valid_q & s2_last_q;
      if (s2_valid_q) begin
        r_q <= clip(sh_r);
        g_q <= clip(sh_g);
        b_q <= clip(sh_b);
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign r_out      = r_q;
  assign g_out      = g_q;
  assign b_out      = b_q;
  assign frame_done = done_q;
  assign busy       = (state_q != StIdle) | s1_valid_q | s2_valid_q | out_valid_q;

`ifdef YUV2RGB_CLIP_CNT_EN
  logic [CNT_W-1:0] clip_cnt_q;
  logic             any_clip;

  assign any_clip = (sh_r < 0) | (sh_r > MAXV) | (sh_g < 0) | (sh_g > MAXV) |
                    (sh_b < 0) | (sh_b > MAXV);

  always_ff @(posedge clk) begin
    if (rst) begin
      clip_cnt_q <= '0;
    end else if ((state_q == StIdle) && start) begin
      clip_cnt_q <= '0;
    end else if (adv && s2_valid_q && any_clip && (clip_cnt_q != '1)) begin
      clip_cnt_q <= clip_cnt_q + CNT_W'(1);
    end
  end

  assign clip_cnt = clip_cnt_q;
`endif

endmodule

// File: tb/tb_yuv_to_rgb_pipe.sv
// Scoreboard bench for yuv_to_rgb_pipe: directed frames with hand-computed RGB results.
module tb_yuv_to_rgb_pipe;

  logic        clk = 1'b0;
  logic        rst, start, mode, in_valid, in_ready, out_valid, out_ready;
  logic [17:0] frame_pixels;
  logic [7:0]  y_in, u_in, v_in, r_out, g_out, b_out;
  logic        out_last, busy, frame_done;
`ifdef YUV2RGB_CLIP_CNT_EN
  logic [17:0] clip_cnt;
`endif

  yuv_to_rgb_pipe dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .frame_pixels(frame_pixels),
    .mode        (mode),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .y_in        (y_in),
    .u_in        (u_in),
    .v_in        (v_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .r_out       (r_out),
    .g_out       (g_out),
    .b_out       (b_out),
    .out_last    (out_last),
    .busy        (busy),
    .frame_done  (frame_done)
`ifdef YUV2RGB_CLIP_CNT_EN
    ,
    .clip_cnt    (clip_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] rgb;
    logic        last;
    int          cyc;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  int    done_cnt = 0;
  int    done_exp_cyc = -10;
  int    zero_done_cyc = -10;
  logic  check_lat = 1'b1;
  logic  hold_pend = 1'b0;
  logic [24:0] held;
  logic  send_done;

  // Stream table: Y/U/V and expected RGB
  logic [7:0]  ty[8] = '{8'd16, 8'd235, 8'd81, 8'd126, 8'd60, 8'd255, 8'd126, 8'd60};
  logic [7:0]  tu[8] = '{8'd128, 8'd128, 8'd90, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128};
  logic [7:0]  tv[8] = '{8'd128, 8'd128, 8'd240, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128};
  logic [23:0] te[8] = '{24'h000000, 24'hffffff, 24'hfe0000, 24'h808080,
                         24'h333333, 24'hffffff, 24'h808080, 24'h333333};

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic start_frame(input logic [17:0] n, input logic m);
    @(posedge clk); #1;
    start = 1'b1; frame_pixels = n; mode = m;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_pix(input logic [7:0] y, input logic [7:0] u, input logic [7:0] v,
                          input logic [23:0] rgb, input logic last);
    int t = 0;
    in_valid = 1'b1; y_in = y; u_in = u; v_in = v;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    else sb.push_back('{rgb: rgb, last: last, cyc: cyc});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    @(negedge clk);
    while ((busy || sb.size() != 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check({name, "_drain"}, int'(!busy && sb.size() == 0), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic ref_frame();
    int d0 = done_cnt;
    check_lat = 1'b1;
    start_frame(18'd3, 1'b0);
    send_pix(8'd16, 8'd128, 8'd128, 24'h000000, 1'b0);
    send_pix(8'd235, 8'd128, 8'd128, 24'hffffff, 1'b0);
    send_pix(8'd81, 8'd90, 8'd240, 24'hfe0000, 1'b1);
    wait_idle("ref_frame");
    check("ref_frame_done_count", done_cnt - d0, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; frame_pixels = '0;
    in_valid = 1'b0; out_ready = 1'b1; y_in = '0; u_in = '0; v_in = '0;
    send_done = 1'b0;
    fork
      begin : monitor
        exp_t e;
        forever begin
          @(negedge clk);
          if (rst) begin
            hold_pend = 1'b0;
            continue;
          end
          if (hold_pend) begin
            check("stall_valid_held", int'(out_valid), 1);
            check("stall_data_held", int'({out_last, r_out, g_out, b_out}), int'(held));
          end
          hold_pend = out_valid && !out_ready;
          held = {out_last, r_out, g_out, b_out};
          if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
              check("unexpected_output", int'({r_out, g_out, b_out}), -1);
            end else begin
              e = sb.pop_front();
              check("rgb", int'({r_out, g_out, b_out}), int'(e.rgb));
              check("out_last", int'(out_last), int'(e.last));
              if (check_lat) check("latency", cyc - e.cyc, 3);
              if (out_last) done_exp_cyc = cyc + 1;
            end
          end
          if (frame_done) begin
            check("frame_done_timing", int'(cyc == done_exp_cyc || cyc == zero_done_cyc), 1);
            done_cnt++;
          end
        end
      end
      begin : main
        int d0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_rgb_last", int'({out_last, r_out, g_out, b_out}), 0);
        rst = 1'b0;

        // Reference BT.601 frame
        ref_frame();

        // Over-range luma clips to white
        d0 = done_cnt;
        start_frame(18'd1, 1'b0);
        send_pix(8'd255, 8'd128, 8'd128, 24'hffffff, 1'b1);
        wait_idle("white_clip");
        check("white_clip_done", done_cnt - d0, 1);
`ifdef YUV2RGB_CLIP_CNT_EN
        check("clip_cnt", int'(clip_cnt), 1);
`endif

        // Stream with out_ready toggling every cycle
        d0 = done_cnt;
        check_lat = 1'b0;
        start_frame(18'd8, 1'b0);
        send_done = 1'b0;
        fork
          begin
            for (int i = 0; i < 8; i++) send_pix(ty[i], tu[i], tv[i], te[i], i == 7);
            send_done = 1'b1;
          end
          begin
            while (!send_done) begin
              @(posedge clk); #1;
              out_ready = ~out_ready;
            end
          end
        join
        out_ready = 1'b1;
        wait_idle("stream");
        check("stream_done", done_cnt - d0, 1);
        check_lat = 1'b1;

        // Zero-length frame
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; frame_pixels = '0; in_valid = 1'b1;
        zero_done_cyc = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("zero_in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        check("zero_done", done_cnt - d0, 1);
        check("zero_busy", int'(busy), 0);

        // Reset with two pixels in flight
        d0 = done_cnt;
        start_frame(18'd4, 1'b0);
        send_pix(8'd235, 8'd128, 8'd128, 24'hffffff, 1'b0);
        send_pix(8'd126, 8'd128, 8'd128, 24'h808080, 1'b0);
        sb.delete();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_rgb_last", int'({out_last, r_out, g_out, b_out}), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        repeat (6) @(negedge clk);
        check("midrst_no_done", done_cnt - d0, 0);
        check("midrst_still_idle", int'(busy), 0);
        ref_frame();

        // BT.709 frame; a start pulse mid-frame must not reload count or mode
        d0 = done_cnt;
        start_frame(18'd2, 1'b1);
        send_pix(8'd81, 8'd90, 8'd240, 24'hff1800, 1'b0);
        start_frame(18'd5, 1'b0);
        send_pix(8'd81, 8'd90, 8'd240, 24'hff1800, 1'b1);
        wait_idle("bt709");
        check("bt709_done", done_cnt - d0, 1);
        check("bt709_in_ready_after", int'(in_ready), 0);
      end
      begin : watchdog
        repeat (20000) @(posedge clk);
        check("watchdog_timeout", 0, 1);
      end
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
